// File: rtl/prio_seg_scan_pkg.sv
// Shared constants for the priority encoder / seven-segment scanner:
// the hex font, the dash and blank glyphs, and a clog2 helper.
// All segment codes are active-low, bits 7..1 = a..g, bit 0 = dp (kept off).
package prio_seg_pkg;

    localparam logic [7:0] SEG_DASH  = 8'hFD;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [7:0] SEG_FONT [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    // Smallest r with 2**r >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_seg_scan_if.sv
// Board-side bundle of prio_seg_scan: switch inputs and control in,
// encoded result and seven-segment/anode pins out.
interface prio_seg_scan_if
    import prio_seg_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 2
);
    localparam int IDX_W = clog2(IN_W);

    logic [IN_W-1:0]   x;
    logic              en;
    logic              hold;
    logic [IDX_W-1:0]  y;
    logic              sig;
    logic              chg;
    logic [7:0]        seg;
    logic [DIGITS-1:0] an;

    modport master (output x, en, hold, input y, sig, chg, seg, an);
    modport slave  (input x, en, hold, output y, sig, chg, seg, an);

endinterface

// File: rtl/prio_seg_scan_seg_scan.sv
// Multiplexed seven-segment driver: cnt/dp scan counter, one-hot-low anode
// decode and nibble-to-font lookup. Shows a dash on every digit when the
// value is not valid.
// Optional build macro: PRIO_SEG_BLANK_EN enables leading-zero blanking
// (digit 0 is never blanked).
module seg_scan
    import prio_seg_pkg::*;
#(
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 1000,
    parameter int VAL_W    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [VAL_W-1:0]  i_val,
    input  logic              i_sig,
    output logic [7:0]        o_seg,
    output logic [DIGITS-1:0] o_an
);
    localparam int CNT_W = (SCAN_DIV > 1) ? clog2(SCAN_DIV) : 1;
    localparam int DP_W  = (DIGITS > 1) ? clog2(DIGITS) : 1;
    localparam int EXT_W = 4 * DIGITS;

    logic [CNT_W-1:0] r_cnt;
    logic [DP_W-1:0]  r_dp;
    logic [EXT_W-1:0] w_ext;
    logic [3:0]       w_nib;
    logic             w_blank;

    assign w_ext = EXT_W'(i_val);

    // Dwell counter; the digit pointer steps when the dwell expires.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_dp  <= '0;
        end else if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
            r_cnt <= '0;
            r_dp  <= (r_dp == DP_W'(DIGITS - 1)) ? '0 : r_dp + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_an = ~(DIGITS'(1) << r_dp);

    // Select the nibble belonging to the digit currently driven.
    always_comb begin
        w_nib = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_dp == DP_W'(d)) w_nib = w_ext[4*d +: 4];
        end
    end

`ifdef PRIO_SEG_BLANK_EN
    logic [DP_W-1:0] w_top;

    // Locate the most significant nonzero digit; digit 0 is the floor.
    always_comb begin
        w_top = '0;
        for (int d = 1; d < DIGITS; d++) begin
            if (w_ext[4*d +: 4] != 4'h0) w_top = DP_W'(d);
        end
    end

    assign w_blank = (r_dp > w_top);
`else
    assign w_blank = 1'b0;
`endif

    // Glyph for the active digit.
    always_comb begin
        o_seg = SEG_DASH;
        if (i_sig) o_seg = w_blank ? SEG_BLANK : SEG_FONT[w_nib];
    end

endmodule

// File: rtl/prio_seg_scan.sv
// Priority encoder with registered result, valid flag, hold/freeze and a
// change pulse, driving a scanned multi-digit hex display of the index.
// Optional build macro: PRIO_SEG_BLANK_EN (leading-zero blanking in seg_scan).
module prio_seg_scan
    import prio_seg_pkg::*;
#(
    parameter int IN_W     = 16,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 1000
) (
    input  logic          clk,
    input  logic          rst,
    prio_seg_scan_if.slave bus
);
    localparam int IDX_W = clog2(IN_W);

    logic [IDX_W-1:0]  w_idx;
    logic              w_vld;
    logic [IDX_W-1:0]  r_y;
    logic              r_sig;
    logic              r_chg;
    logic [7:0]        w_seg;
    logic [DIGITS-1:0] w_an;

    // Highest set bit wins; a disabled or empty request reports index 0, invalid.
    always_comb begin
        w_idx = '0;
        w_vld = 1'b0;
        if (bus.en) begin
            for (int i = 0; i < IN_W; i++) begin
                if (bus.x[i]) begin
                    w_idx = IDX_W'(i);
                    w_vld = 1'b1;
                end
            end
        end
    end

    // Result register; hold freezes it and suppresses the change pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y   <= '0;
            r_sig <= 1'b0;
            r_chg <= 1'b0;
        end else if (bus.hold) begin
            r_chg <= 1'b0;
        end else begin
            r_y   <= w_idx;
            r_sig <= w_vld;
            r_chg <= ({w_vld, w_idx} != {r_sig, r_y});
        end
    end

    seg_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .VAL_W    (IDX_W)
    ) u_seg_scan (
        .clk   (clk),
        .rst   (rst),
        .i_val (r_y),
        .i_sig (r_sig),
        .o_seg (w_seg),
        .o_an  (w_an)
    );

    assign bus.y   = r_y;
    assign bus.sig = r_sig;
    assign bus.chg = r_chg;
    assign bus.seg = w_seg;
    assign bus.an  = w_an;

endmodule

// File: tb/tb_prio_seg_scan.sv
// Scoreboard bench for prio_seg_scan: three instances (16-bit/2 digits with
// SCAN_DIV=1, 8-bit/3 digits with SCAN_DIV=4, 256-bit/2 digits), directed
// vectors push expected outputs, monitors pop and compare after each edge.
module tb_prio_seg_scan;
    import prio_seg_pkg::*;

`ifdef PRIO_SEG_BLANK_EN
    localparam logic [7:0] Z1 = 8'hFF;
`else
    localparam logic [7:0] Z1 = 8'h03;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prio_seg_scan_if #(.IN_W(16),  .DIGITS(2)) m_if ();
    prio_seg_scan_if #(.IN_W(8),   .DIGITS(3)) s_if ();
    prio_seg_scan_if #(.IN_W(256), .DIGITS(2)) w_if ();

    prio_seg_scan #(.IN_W(16), .DIGITS(2), .SCAN_DIV(1)) u_main (
        .clk(clk), .rst(rst), .bus(m_if.slave));
    prio_seg_scan #(.IN_W(8), .DIGITS(3), .SCAN_DIV(4)) u_scan (
        .clk(clk), .rst(rst), .bus(s_if.slave));
    prio_seg_scan #(.IN_W(256), .DIGITS(2), .SCAN_DIV(1)) u_wide (
        .clk(clk), .rst(rst), .bus(w_if.slave));

    typedef struct {
        logic [7:0] y;
        logic       sig;
        logic       chg;
        logic [7:0] seg0;
        logic [7:0] seg1;
    } exp_t;

    typedef struct {
        logic [2:0] an;
        logic [7:0] seg;
    } scan_exp_t;

    exp_t      q_main [$];
    exp_t      q_wide [$];
    scan_exp_t q_scan [$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Main monitor: tracks the expected digit pointer (SCAN_DIV=1 toggles each edge).
    initial begin : mon_main
        exp_t e;
        int   edp;
        edp = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) edp = 0;
            else     edp = 1 - edp;
            #1;
            if (q_main.size() > 0) begin
                e = q_main.pop_front();
                chk("main_y",   32'(m_if.y),   32'(e.y));
                chk("main_sig", 32'(m_if.sig), 32'(e.sig));
                chk("main_chg", 32'(m_if.chg), 32'(e.chg));
                chk("main_an",  32'(m_if.an),  (edp == 1) ? 32'h1 : 32'h2);
                chk("main_seg", 32'(m_if.seg), 32'((edp == 1) ? e.seg1 : e.seg0));
            end
        end
    end

    // Wide-input monitor, same scan model as main.
    initial begin : mon_wide
        exp_t e;
        int   edp;
        edp = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) edp = 0;
            else     edp = 1 - edp;
            #1;
            if (q_wide.size() > 0) begin
                e = q_wide.pop_front();
                chk("wide_y",   32'(w_if.y),   32'(e.y));
                chk("wide_sig", 32'(w_if.sig), 32'(e.sig));
                chk("wide_chg", 32'(w_if.chg), 32'(e.chg));
                chk("wide_seg", 32'(w_if.seg), 32'((edp == 1) ? e.seg1 : e.seg0));
            end
        end
    end

    // Scan monitor: anode pattern and glyph after each edge.
    initial begin : mon_scan
        scan_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_scan.size() > 0) begin
                e = q_scan.pop_front();
                chk("scan_an",  32'(s_if.an),  32'(e.an));
                chk("scan_seg", 32'(s_if.seg), 32'(e.seg));
            end
        end
    end

    task automatic mstep(input logic [15:0] x, input logic en, input logic hold,
                         input logic [7:0] ey, input logic es, input logic ec,
                         input logic [7:0] s0, input logic [7:0] s1);
        @(negedge clk);
        m_if.x    = x;
        m_if.en   = en;
        m_if.hold = hold;
        q_main.push_back('{y: ey, sig: es, chg: ec, seg0: s0, seg1: s1});
    endtask

    // New valid value: change pulse on the first cycle, quiet on the second.
    task automatic vec2(input logic [15:0] x, input logic [7:0] ey, input logic [7:0] s0);
        mstep(x, 1'b1, 1'b0, ey, 1'b1, 1'b1, s0, Z1);
        mstep(x, 1'b1, 1'b0, ey, 1'b1, 1'b0, s0, Z1);
    endtask

    // Scan instance: x=0x80 gives y=7 from the first edge after reset.
    initial begin : stim_scan
        logic [2:0] an_tab [16];
        an_tab = '{3'b110, 3'b110, 3'b110,
                   3'b101, 3'b101, 3'b101, 3'b101,
                   3'b011, 3'b011, 3'b011, 3'b011,
                   3'b110, 3'b110, 3'b110, 3'b110,
                   3'b101};
        s_if.x    = 8'h80;
        s_if.en   = 1'b1;
        s_if.hold = 1'b0;
        @(negedge rst);
        for (int k = 0; k < 16; k++) begin
            q_scan.push_back('{an: an_tab[k], seg: (an_tab[k] == 3'b110) ? 8'h1F : Z1});
            @(negedge clk);
        end
    end

    // Wide instance: top bit, a mid bit and bit 0.
    initial begin : stim_wide
        w_if.x    = '0;
        w_if.en   = 1'b0;
        w_if.hold = 1'b0;
        @(negedge rst);
        @(negedge clk);
        w_if.x = '0; w_if.x[255] = 1'b1; w_if.en = 1'b1;
        q_wide.push_back('{y: 8'hFF, sig: 1'b1, chg: 1'b1, seg0: 8'h71, seg1: 8'h71});
        @(negedge clk);
        q_wide.push_back('{y: 8'hFF, sig: 1'b1, chg: 1'b0, seg0: 8'h71, seg1: 8'h71});
        @(negedge clk);
        w_if.x = '0; w_if.x[16] = 1'b1;
        q_wide.push_back('{y: 8'h10, sig: 1'b1, chg: 1'b1, seg0: 8'h03, seg1: 8'h9F});
        @(negedge clk);
        q_wide.push_back('{y: 8'h10, sig: 1'b1, chg: 1'b0, seg0: 8'h03, seg1: 8'h9F});
        @(negedge clk);
        w_if.x = '0; w_if.x[0] = 1'b1;
        q_wide.push_back('{y: 8'h00, sig: 1'b1, chg: 1'b1, seg0: 8'h03, seg1: Z1});
        @(negedge clk);
        q_wide.push_back('{y: 8'h00, sig: 1'b1, chg: 1'b0, seg0: 8'h03, seg1: Z1});
    end

    initial begin : watchdog
        #100000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : stim_main
        m_if.x    = '0;
        m_if.en   = 1'b0;
        m_if.hold = 1'b0;
        @(negedge clk);
        q_main.push_back('{y: 8'h0, sig: 1'b0, chg: 1'b0, seg0: SEG_DASH, seg1: SEG_DASH});
        @(negedge clk);
        rst = 1'b0;

        mstep(16'h0A40, 1'b1, 1'b0, 8'd11, 1'b1, 1'b1, 8'hC1, Z1);
        mstep(16'h0A40, 1'b1, 1'b0, 8'd11, 1'b1, 1'b0, 8'hC1, Z1);
        mstep(16'hFFFF, 1'b0, 1'b0, 8'd0,  1'b0, 1'b1, SEG_DASH, SEG_DASH);
        mstep(16'h0000, 1'b1, 1'b0, 8'd0,  1'b0, 1'b0, SEG_DASH, SEG_DASH);
        mstep(16'h0020, 1'b1, 1'b0, 8'd5,  1'b1, 1'b1, 8'h49, Z1);
        mstep(16'h0020, 1'b1, 1'b0, 8'd5,  1'b1, 1'b0, 8'h49, Z1);
        mstep(16'h8000, 1'b1, 1'b1, 8'd5,  1'b1, 1'b0, 8'h49, Z1);
        mstep(16'h8000, 1'b1, 1'b1, 8'd5,  1'b1, 1'b0, 8'h49, Z1);
        mstep(16'h8000, 1'b1, 1'b0, 8'd15, 1'b1, 1'b1, 8'h71, Z1);
        mstep(16'h8000, 1'b1, 1'b0, 8'd15, 1'b1, 1'b0, 8'h71, Z1);
        mstep(16'h0001, 1'b1, 1'b0, 8'd0,  1'b1, 1'b1, 8'h03, Z1);
        mstep(16'h0003, 1'b1, 1'b0, 8'd1,  1'b1, 1'b1, 8'h9F, Z1);
        mstep(16'h0000, 1'b0, 1'b1, 8'd1,  1'b1, 1'b0, 8'h9F, Z1);

        vec2(16'h0100, 8'd8,  8'h01);
        vec2(16'h0200, 8'd9,  8'h09);
        vec2(16'h0400, 8'd10, 8'h11);
        vec2(16'h1000, 8'd12, 8'h63);
        vec2(16'h2000, 8'd13, 8'h85);
        vec2(16'h4000, 8'd14, 8'h61);
        vec2(16'h0004, 8'd2,  8'h25);
        vec2(16'h0008, 8'd3,  8'h0D);
        vec2(16'h0010, 8'd4,  8'h99);
        vec2(16'h0040, 8'd6,  8'h41);
        vec2(16'h0080, 8'd7,  8'h1F);

        // Asynchronous reset in mid-scan, then restart from digit 0.
        @(negedge clk);
        #2;
        rst = 1'b1;
        q_main.push_back('{y: 8'h0, sig: 1'b0, chg: 1'b0, seg0: SEG_DASH, seg1: SEG_DASH});
        @(negedge clk);
        rst       = 1'b0;
        m_if.x    = 16'h0A40;
        m_if.en   = 1'b1;
        m_if.hold = 1'b0;
        q_main.push_back('{y: 8'd11, sig: 1'b1, chg: 1'b1, seg0: 8'hC1, seg1: Z1});
        mstep(16'h0A40, 1'b1, 1'b0, 8'd11, 1'b1, 1'b0, 8'hC1, Z1);

        repeat (3) @(negedge clk);
        if (q_main.size() != 0 || q_wide.size() != 0 || q_scan.size() != 0) begin
            n_bad++;
            $display("FAIL drain: entries left main=%0d wide=%0d scan=%0d",
                     q_main.size(), q_wide.size(), q_scan.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/prio_seg_scan.md
# prio_seg_scan

Parametrised priority encoder with registered result and a time-multiplexed multi-digit seven-segment driver. Reports the index of the highest set bit of an IN_W-bit input in hex across DIGITS scanned digits, with a valid flag, hold/freeze control and a change pulse. Sits between board switch inputs and the seven-segment/anode pins, replacing the single-digit 8-to-3 combinational encoder.

## Interface
- IN_W, 16: input vector width, 2..256.
- DIGITS, 2: displayed hex digits, 1..8. Must satisfy IDX_W <= 4*DIGITS, where IDX_W = clog2(IN_W).
- SCAN_DIV, 1000: clocks each digit stays selected, >= 1.
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- x  in  IN_W  request vector.
- en  in  1  encoder enable.
- hold  in  1  freeze the registered result.
- y  out  IDX_W  registered index of the highest set bit of x.
- sig  out  1  registered valid: en=1 and x != 0.
- chg  out  1  one-cycle pulse when {sig,y} changes value.
- seg  out  8  active-low segments: bits 7..1 = a..g, bit 0 = dp.
- an  out  DIGITS  active-low digit select, one-hot-low.

## Operation
- Encode (combinational): idx = highest i with x[i]=1. If en=0 or x=0, then idx=0 and vld=0. Otherwise vld=1.
- Result register: if hold=0, {sig,y} <= {vld,idx} every cycle. If hold=1, both keep their value. hold overrides en and x.
- chg: registered. It is 1 in the cycle after the register's next value differs from its current value. It is never 1 while hold=1.
- Scan counter cnt runs 0..SCAN_DIV-1. At terminal count it wraps to 0, and digit pointer dp advances 0..DIGITS-1, wrapping to 0. With DIGITS=1, dp stays 0.
- an: bit dp is 0, all other bits are 1.
- seg (combinational from dp, y, sig): nibble n = bits [4*dp+3:4*dp] of y, zero-extended to 4*DIGITS bits.
  - sig=0: every digit shows dash 0xFD.
  - sig=1: font of n.
- Font (dp segment off):
  - 0=0x03, 1=0x9F, 2=0x25, 3=0x0D, 4=0x99, 5=0x49, 6=0x41, 7=0x1F
  - 8=0x01, 9=0x09, A=0x11, b=0xC1, C=0x63, d=0x85, E=0x61, F=0x71
  - blank=0xFF.
- Digit 0 is the least significant nibble.

## Timing
- Reset values: y=0, sig=0, chg=0, cnt=0, dp=0, an = all ones except bit 0 = 0, seg=0xFD.
- Latency: x/en to y/sig is 1 cycle. chg is asserted in the same cycle the new y/sig becomes visible. seg follows y/sig and dp with zero added latency.
- hold sampled high freezes y/sig from the next edge. On release, the first update lands 1 cycle later.
- Reset asserted mid-scan immediately forces all reset values, asynchronously. After release, scanning restarts at digit 0 with cnt=0.
- Simultaneous change of x and assertion of hold: hold wins. The old value is kept and chg=0.
- SCAN_DIV=1: dp advances every cycle.

## Configuration
- PRIO_SEG_BLANK_EN defined: leading-zero blanking. When sig=1, any digit above the most significant nonzero nibble of y shows 0xFF. Digit 0 is never blanked, so y=0 shows "0".
- PRIO_SEG_BLANK_EN undefined: all digits always show their nibble, including leading zeros.
- Neither setting affects y, sig, chg or an.

## Structure
- Shared package prio_seg_pkg holds:
  - the 16-entry hex font constant array,
  - SEG_DASH=8'hFD and SEG_BLANK=8'hFF,
  - a clog2 helper function.
- One sub-module, seg_scan: cnt/dp counter, an decode and nibble-to-font lookup. Parameters DIGITS and SCAN_DIV; inputs are the value and sig.
- The priority encoder and result register stay in the top module.

## Test plan
- Reset: rst=1 mid-operation -> immediately y=0, sig=0, chg=0, seg=0xFD, an=2'b10 (IN_W=16, DIGITS=2).
- Priority: en=1, x=16'h0A40 -> next cycle y=11, sig=1, chg=1 for one cycle. Digit 0 shows 0xC1 ("b"), digit 1 shows 0x03, or 0xFF with PRIO_SEG_BLANK_EN.
- Invalid: en=0 with x=16'hFFFF, then en=1 with x=0 -> y=0, sig=0 in both cases, both digits 0xFD.
- Hold: y=5, hold=1, x changes to 16'h8000 -> y stays 5 and chg=0. Release hold -> y=15 one cycle later, chg pulses once.
- Scan: SCAN_DIV=4, DIGITS=3 -> an cycles 110, 101, 011, 110, each held exactly 4 clocks.
- Wide input: IN_W=256, DIGITS=2, x bit 255 only set -> y=8'hFF, both digits 0x71 ("F").
